// File: rtl/ofdm_buf_reader.sv
// Read-side controller for the ping-pong OFDM symbol buffer: streams one filled
// bank in address order over valid/ready and hands the bank back with buf_done.
module ofdm_buf_reader #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int BLK_LEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              buf_rdy,
    output logic              buf_done,
    output logic              busy,
    output logic              ovf_err,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    // Handshake: a byte transfers on any cycle where m_valid && m_ready are both
    // high; m_data/m_last hold steady while m_valid is high and m_ready is low.

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BLK_LEN - 1);

    state_t              state, state_nxt;
    logic [1:0]          pend_cnt;
    logic                cur_bank;
    logic [ADDR_W-1:0]   rd_cnt;
    logic                inflight, inflight_last;
    logic [DATA_W-1:0]   fifo_data [2];
    logic                fifo_last [2];
    logic                wr_ptr, rd_ptr;
    logic [1:0]          fifo_cnt;
    logic [2:0]          occ;
    logic                start, issue, pop, last_pop;

    assign pop     = m_valid & m_ready;
    assign m_valid = (fifo_cnt != 2'd0);
    assign m_data  = fifo_data[rd_ptr];
    assign m_last  = fifo_last[rd_ptr] & m_valid;
    assign busy    = (state != IDLE);
    assign ram_we  = 1'b0;
    assign ram_en  = issue;
    assign ram_addr = {cur_bank, rd_cnt[ADDR_W-2:0]};

    // Bytes held or arriving after this cycle's pop; the read is issued only
    // while this stays below the FIFO depth, so the FIFO cannot overflow.
    assign occ = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        issue     = 1'b0;
        last_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (pend_cnt != 2'd0) begin
                    start     = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                if (!rd_cnt[ADDR_W-1] && (occ < 3'd2)) begin
                    issue = 1'b1;
                    if (rd_cnt == LAST_IDX) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    last_pop  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pend_cnt      <= 2'd0;
            ovf_err       <= 1'b0;
            cur_bank      <= 1'b0;
            rd_cnt        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            buf_done      <= 1'b0;
        end else begin
            state         <= state_nxt;
            buf_done      <= last_pop;
            inflight      <= issue;
            inflight_last <= issue && (rd_cnt == LAST_IDX);
            if (last_pop) cur_bank <= ~cur_bank;
            if (start) rd_cnt <= '0;
            else if (issue) rd_cnt <= rd_cnt + 1'b1;
            // A start and a new bank in the same cycle cancel out.
            case ({buf_rdy, start})
                2'b10: begin
                    if (pend_cnt == 2'd2) ovf_err <= 1'b1;
                    else pend_cnt <= pend_cnt + 2'd1;
                end
                2'b01:   pend_cnt <= pend_cnt - 2'd1;
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (inflight) begin
                fifo_data[wr_ptr] <= ram_dout;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ofdm_buf_reader.sv
// Bench for ofdm_buf_reader: behavioural RAM, scoreboard of expected bytes per
// issued read, and scenario tasks checking latency, ping-pong, overflow, reset.
module tb_ofdm_buf_reader;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int BLK_LEN = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              buf_rdy = 1'b0;
    logic              m_ready = 1'b1;
    logic              buf_done, busy, ovf_err, ram_we, ram_en, m_valid, m_last;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout, m_data;

    logic [DATA_W-1:0] mem [128];
    logic [DATA_W-1:0] exp_q [$];
    logic              last_q [$];

    int n_vec = 0, n_err = 0;
    int pop_cnt = 0, done_cnt = 0, en_cnt = 0, hi_cnt = 0;
    int rand_mode = 0;
    int iss_idx = 0, iss_bank = 0;
    logic done_due = 1'b0, stall_prev = 1'b0, prev_last = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    ofdm_buf_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLK_LEN(BLK_LEN)) dut (
        .clk(clk), .rst(rst), .buf_rdy(buf_rdy), .buf_done(buf_done), .busy(busy),
        .ovf_err(ovf_err), .ram_we(ram_we), .ram_addr(ram_addr), .ram_en(ram_en),
        .ram_dout(ram_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last)
    );

    always #5 clk = ~clk;

    // Registered-read RAM model.
    always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

    // Scoreboard: each read must target the next address of the current bank,
    // its byte must come out in order, and buf_done must follow the last byte.
    always @(negedge clk) begin
        int a;
        logic [DATA_W-1:0] e;
        logic el;
        if (rst) begin
            exp_q.delete(); last_q.delete();
            iss_idx = 0; iss_bank = 0; done_due = 1'b0; stall_prev = 1'b0;
        end else begin
            if (buf_done || done_due) begin
                n_vec++;
                if (buf_done !== done_due) begin
                    n_err++; $display("FAIL buf_done_timing: got %b want %b", buf_done, done_due);
                end
            end
            if (buf_done) done_cnt++;
            done_due = 1'b0;
            if (stall_prev) begin
                n_vec++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                    n_err++;
                    $display("FAIL hold_stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             m_valid, m_data, m_last, prev_data, prev_last);
                end
            end
            if (m_valid && m_ready) begin
                pop_cnt++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL unexpected_byte: got %h want none", m_data);
                end else begin
                    e  = exp_q.pop_front();
                    el = last_q.pop_front();
                    if (m_data !== e || m_last !== el) begin
                        n_err++;
                        $display("FAIL stream_byte: got d=%h l=%b want d=%h l=%b", m_data, m_last, e, el);
                    end
                    if (el) done_due = 1'b1;
                end
            end
            if (ram_en) begin
                a = iss_bank * BLK_LEN + iss_idx;
                n_vec++;
                if (ram_addr !== ADDR_W'(a) || ram_we !== 1'b0) begin
                    n_err++;
                    $display("FAIL read_addr: got a=%0d we=%b want a=%0d we=0", ram_addr, ram_we, a);
                end
                exp_q.push_back(mem[a]);
                last_q.push_back(iss_idx == BLK_LEN - 1);
                en_cnt++;
                if (ram_addr >= ADDR_W'(BLK_LEN)) hi_cnt++;
                iss_idx++;
                if (iss_idx == BLK_LEN) begin
                    iss_idx  = 0;
                    iss_bank = 1 - iss_bank;
                end
            end
            if (exp_q.size() > 2) begin
                n_vec++; n_err++;
                $display("FAIL outstanding: got %0d want <=2", exp_q.size());
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        if (rand_mode != 0) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic fill_spec();
        for (int i = 0; i < BLK_LEN; i++) begin
            mem[i]           = DATA_W'(i);
            mem[i + BLK_LEN] = DATA_W'(8'h80 + i);
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 128; i++) mem[i] = DATA_W'($urandom_range(0, 255));
    endtask

    task automatic do_reset();
        rst = 1'b1; buf_rdy = 1'b0; m_ready = 1'b1; rand_mode = 0;
        repeat (2) tick();
        rst = 1'b0;
        pop_cnt = 0; done_cnt = 0; en_cnt = 0; hi_cnt = 0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int c = 0; c < budget && done_cnt < target; c++) tick();
        n_vec++;
        if (done_cnt < target) begin
            n_err++; $display("FAIL done_timeout: got %0d want %0d", done_cnt, target);
        end
        repeat (4) tick();
    endtask

    task automatic wait_first_read(input int budget, input int want_addr);
        int c;
        c = 0;
        @(negedge clk);
        while (!ram_en && c < budget) begin
            tick(); @(negedge clk); c++;
        end
        n_vec++;
        if (!ram_en || ram_addr !== ADDR_W'(want_addr)) begin
            n_err++; $display("FAIL first_addr: got en=%b a=%0d want en=1 a=%0d", ram_en, ram_addr, want_addr);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; buf_rdy = 1'b0; m_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        n_vec++;
        if ({m_valid, busy, buf_done, ovf_err, ram_en, ram_we, m_last} !== 7'b0 || ram_addr !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v%b b%b d%b o%b e%b w%b l%b a=%0d want all 0",
                     m_valid, busy, buf_done, ovf_err, ram_en, ram_we, m_last, ram_addr);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        int fe, fv, lc, dc;
        logic b69;
        fe = -1; fv = -1; lc = -1; dc = -1; b69 = 1'b1;
        fill_spec();
        do_reset();
        buf_rdy = 1'b1;
        for (int c = 0; c < 72; c++) begin
            @(negedge clk);
            if (ram_en && fe < 0) fe = c;
            if (m_valid && fv < 0) fv = c;
            if (m_valid && m_ready && m_last) lc = c;
            if (buf_done && dc < 0) dc = c;
            if (c == 69) b69 = busy;
            tick();
            buf_rdy = 1'b0;
        end
        n_vec++; if (fe != 2)  begin n_err++; $display("FAIL first_ram_en: got %0d want 2", fe); end
        n_vec++; if (fv != 4)  begin n_err++; $display("FAIL first_valid: got %0d want 4", fv); end
        n_vec++; if (lc != 67) begin n_err++; $display("FAIL last_cycle: got %0d want 67", lc); end
        n_vec++; if (dc != 68) begin n_err++; $display("FAIL done_cycle: got %0d want 68", dc); end
        n_vec++; if (b69 !== 1'b0) begin n_err++; $display("FAIL busy_after: got %b want 0", b69); end
        n_vec++; if (pop_cnt != 64 || done_cnt != 1) begin
            n_err++; $display("FAIL single_counts: got pops=%0d dones=%0d want 64 1", pop_cnt, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        int stall_at;
        fill_rand();
        do_reset();
        stall_at = $urandom_range(12, 40);
        buf_rdy = 1'b1;
        for (int c = 0; c < 600 && done_cnt == 0; c++) begin
            tick();
            buf_rdy = 1'b0;
            if (c < 8) m_ready = (c % 2 == 1);
            else if (c >= stall_at && c < stall_at + 3) m_ready = 1'b0;
            else m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
        repeat (10) tick();
        n_vec++;
        if (pop_cnt != 64 || done_cnt != 1) begin
            n_err++; $display("FAIL bp_counts: got pops=%0d dones=%0d want 64 1", pop_cnt, done_cnt);
        end
    endtask

    task automatic test_ping_pong();
        fill_spec();
        do_reset();
        buf_rdy = 1'b1;
        tick();
        buf_rdy = 1'b0;
        repeat (9) tick();
        buf_rdy = 1'b1;
        tick();
        buf_rdy = 1'b0;
        wait_done(2, 400);
        n_vec++;
        if (pop_cnt != 128 || en_cnt != 128 || hi_cnt != 64) begin
            n_err++;
            $display("FAIL pingpong_counts: got pops=%0d reads=%0d hi=%0d want 128 128 64", pop_cnt, en_cnt, hi_cnt);
        end
        buf_rdy = 1'b1;
        tick();
        buf_rdy = 1'b0;
        wait_first_read(10, 0);
        wait_done(3, 200);
    endtask

    task automatic test_overflow();
        fill_rand();
        do_reset();
        buf_rdy = 1'b1;
        tick();
        buf_rdy = 1'b0;
        repeat (9) tick();
        buf_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 2) begin
                n_vec++;
                if (ovf_err !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", ovf_err); end
            end
            tick();
        end
        buf_rdy = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ovf_err !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", ovf_err); end
        rand_mode = 1;
        wait_done(3, 900);
        rand_mode = 0; m_ready = 1'b1;
        repeat (80) tick();
        n_vec++;
        if (done_cnt != 3 || pop_cnt != 192 || ovf_err !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_result: got dones=%0d pops=%0d ovf=%b busy=%b want 3 192 1 0",
                     done_cnt, pop_cnt, ovf_err, busy);
        end
    endtask

    task automatic test_simultaneous();
        int d1, d2, s2;
        d1 = -1; d2 = -1; s2 = -1;
        fill_spec();
        do_reset();
        buf_rdy = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (buf_done && d1 >= 0 && d2 < 0) d2 = c;
            if (buf_done && d1 < 0) d1 = c;
            if (ram_en && d1 >= 0 && s2 < 0) s2 = c;
            tick();
            buf_rdy = (c == 0);
        end
        n_vec++; if (d1 != 68)  begin n_err++; $display("FAIL sim_done1: got %0d want 68", d1); end
        n_vec++; if (s2 != 69)  begin n_err++; $display("FAIL sim_start2: got %0d want 69", s2); end
        n_vec++; if (d2 != 135) begin n_err++; $display("FAIL sim_done2: got %0d want 135", d2); end
        n_vec++;
        if (done_cnt != 2 || ovf_err !== 1'b0) begin
            n_err++; $display("FAIL sim_blocks: got dones=%0d ovf=%b want 2 0", done_cnt, ovf_err);
        end
    endtask

    task automatic test_reset_mid();
        fill_rand();
        do_reset();
        buf_rdy = 1'b1;
        tick();
        buf_rdy = 1'b0;
        repeat (4) tick();
        buf_rdy = 1'b1;
        repeat (3) tick();
        buf_rdy = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ovf_err !== 1'b1) begin n_err++; $display("FAIL mid_ovf_pre: got %b want 1", ovf_err); end
        repeat (12) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || buf_done !== 1'b0 || ovf_err !== 1'b0 || done_cnt != 0) begin
            n_err++;
            $display("FAIL mid_reset: got v=%b b=%b d=%b o=%b dones=%0d want 0 0 0 0 0",
                     m_valid, busy, buf_done, ovf_err, done_cnt);
        end
        repeat (10) tick();
        n_vec++;
        if (busy !== 1'b0 || done_cnt != 0) begin
            n_err++; $display("FAIL mid_idle: got busy=%b dones=%0d want 0 0", busy, done_cnt);
        end
        pop_cnt = 0;
        buf_rdy = 1'b1;
        tick();
        buf_rdy = 1'b0;
        wait_first_read(10, 0);
        wait_done(1, 200);
        n_vec++;
        if (pop_cnt != 64) begin n_err++; $display("FAIL mid_fresh: got pops=%0d want 64", pop_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_ping_pong();
        test_overflow();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
